// File: rtl/seqgen_pkg.sv
// -----------------------------------------------------------------------------
// seqgen_pkg
// Shared definitions for the serial pattern generator and the detector benches
// that consume its stream: FSM state encoding, pattern-select encoding and the
// four 5-bit pattern constants (sent MSB first).
// -----------------------------------------------------------------------------
package seqgen_pkg;

  localparam int PAT_LEN = 5;

  typedef logic [PAT_LEN-1:0] pattern_t;

  // Index of the first bit on the wire.
  localparam logic [2:0] PAT_MSB = 3'(PAT_LEN - 1);

  typedef enum logic [1:0] {
    SEL_10111 = 2'b00,
    SEL_01010 = 2'b01,
    SEL_10101 = 2'b10,
    SEL_10100 = 2'b11
  } pattern_sel_t;

  localparam pattern_t PAT_10111 = 5'b10111;
  localparam pattern_t PAT_01010 = 5'b01010;
  localparam pattern_t PAT_10101 = 5'b10101;
  localparam pattern_t PAT_10100 = 5'b10100;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_SEND,
    ST_GAP,
    ST_DONE
  } state_t;

endpackage

// File: rtl/seq_pattern_lut.sv
// -----------------------------------------------------------------------------
// seq_pattern_lut
// Maps the 2-bit pattern select onto the 5-bit pattern that is shifted out.
//   sel     in  2  pattern select (seqgen_pkg::pattern_sel_t encoding)
//   pattern out 5  pattern bits, bit 4 is transmitted first
// -----------------------------------------------------------------------------
module seq_pattern_lut
  import seqgen_pkg::*;
(
  input  logic [1:0] sel,
  output pattern_t   pattern
);

  always_comb begin
    pattern = PAT_10111;
    unique case (pattern_sel_t'(sel))
      SEL_10111: pattern = PAT_10111;
      SEL_01010: pattern = PAT_01010;
      SEL_10101: pattern = PAT_10101;
      SEL_10100: pattern = PAT_10100;
      default:   pattern = PAT_10111;
    endcase
  end

endmodule

// File: rtl/sequence_generator.sv
// -----------------------------------------------------------------------------
// sequence_generator
// Command-driven serial pattern source. A command selects one of four 5-bit
// patterns, how many instances to send and how many idle bits to insert
// between instances; the block then streams the bits MSB first.
//
// Parameters
//   IDLE_LEVEL  level of serial_out whenever no pattern bit is being sent
//   COUNT_W     width of sent_count
// Ports
//   clk             in   1        rising-edge clock
//   reset           in   1        synchronous, active-high reset
//   cmd_valid       in   1        command request
//   cmd_ready       out  1        command can be accepted (IDLE, out of reset)
//   cmd_pattern     in   2        pattern select
//   cmd_repeat      in   8        instances to send (0..255)
//   cmd_gap         in   4        idle bits between instances (0..15)
//   abort           in   1        drop the running command, back to IDLE
//   serial_out      out  1        serial stream
//   serial_valid    out  1        serial_out carries a pattern bit
//   pattern_sel_out out  2        pattern currently selected
//   busy            out  1        any state other than IDLE
//   done            out  1        one-cycle pulse on normal completion
//   sent_count      out  COUNT_W  completed instances since last clear (saturating)
// -----------------------------------------------------------------------------
module sequence_generator
  import seqgen_pkg::*;
#(
  parameter logic IDLE_LEVEL = 1'b0,
  parameter int   COUNT_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_pattern,
  input  logic [7:0]         cmd_repeat,
  input  logic [3:0]         cmd_gap,
  input  logic               abort,
  output logic               serial_out,
  output logic               serial_valid,
  output logic [1:0]         pattern_sel_out,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] sent_count
);

  state_t     state, state_nxt;
  logic       reset_q;      // high for the cycle following any reset edge
  logic [7:0] rep_left;     // instances still to complete
  logic [3:0] gap_len;      // latched cmd_gap
  logic [3:0] gap_cnt;      // idle cycles left in the current gap
  logic [2:0] bit_idx;      // pattern bit currently on the wire
  pattern_t   pattern;

  logic accept;
  logic bit0_edge;

  seq_pattern_lut u_lut (
    .sel     (pattern_sel_out),
    .pattern (pattern)
  );

  assign accept    = cmd_valid && cmd_ready;
  // The edge that puts bit 0 on the wire completes an instance.
  assign bit0_edge = (state == ST_SEND) && (bit_idx == 3'd1) && !abort;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: all clocked state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of block order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      reset_q <= 1'b1;
    end else begin
      state   <= state_nxt;
      reset_q <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment first means every path assigns state_nxt,
  // so no latch can be inferred for it.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (accept) state_nxt = ST_ARM;
      ST_ARM: begin
        if (abort)                 state_nxt = ST_IDLE;
        else if (rep_left == 8'd0) state_nxt = ST_DONE;
        else                       state_nxt = ST_SEND;
      end
      ST_SEND: begin
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (bit_idx == 3'd0) begin
          // rep_left was already decremented when bit 0 went out.
          if (rep_left == 8'd0)     state_nxt = ST_DONE;
          else if (gap_len != 4'd0) state_nxt = ST_GAP;
          else                      state_nxt = ST_SEND;
        end
      end
      ST_GAP: begin
        if (abort)                state_nxt = ST_IDLE;
        else if (gap_cnt == 4'd1) state_nxt = ST_SEND;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Command latch, bit/gap counters and instance counter
  // ---------------------------------------------------------------------------
  // NOTE: the reset is synchronous; every register here is a plain flop, so
  // all of them are reset and nothing powers up into an undefined command.
  always_ff @(posedge clk) begin
    if (reset) begin
      pattern_sel_out <= 2'b00;
      sent_count      <= '0;
      rep_left        <= 8'd0;
      gap_len         <= 4'd0;
      gap_cnt         <= 4'd0;
      bit_idx         <= 3'd0;
    end else begin
      if (accept) begin
        rep_left        <= cmd_repeat;
        gap_len         <= cmd_gap;
        pattern_sel_out <= cmd_pattern;
        // A new pattern starts a new count; resending the same one continues.
        if (cmd_pattern != pattern_sel_out) sent_count <= '0;
      end

      // Reload the MSB on entry to SEND, including back-to-back instances.
      if (state_nxt == ST_SEND && (state != ST_SEND || bit_idx == 3'd0))
        bit_idx <= PAT_MSB;
      else if (state == ST_SEND && bit_idx != 3'd0)
        bit_idx <= bit_idx - 3'd1;

      if (state == ST_SEND && state_nxt == ST_GAP)
        gap_cnt <= gap_len;
      else if (state == ST_GAP && gap_cnt != 4'd0)
        gap_cnt <= gap_cnt - 4'd1;

      if (bit0_edge) begin
        rep_left <= rep_left - 8'd1;
        if (sent_count != '1) sent_count <= sent_count + COUNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs, decoded from registered state only
  // ---------------------------------------------------------------------------
  always_comb begin
    cmd_ready    = (state == ST_IDLE) && !reset_q;
    busy         = (state != ST_IDLE);
    done         = (state == ST_DONE);
    serial_valid = (state == ST_SEND);
    serial_out   = IDLE_LEVEL;
    if (state == ST_SEND) serial_out = pattern[bit_idx];
  end

endmodule

// File: tb/tb_sequence_generator.sv
// -----------------------------------------------------------------------------
// tb_sequence_generator
// Self-checking bench: directed command table, hand-written abort/reset
// sequences and randomized traffic, all compared every cycle against a
// queue-based reference model of the expected output stream.
// -----------------------------------------------------------------------------
module tb_sequence_generator;

  localparam int   CW       = 4;            // small counter so saturation is reached
  localparam int   CMAX     = (1 << CW) - 1;
  localparam logic IDLE_LVL = 1'b0;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_pattern = 2'b00;
  logic [7:0]    cmd_repeat = 8'd0;
  logic [3:0]    cmd_gap = 4'd0;
  logic          abort = 1'b0;
  logic          serial_out;
  logic          serial_valid;
  logic [1:0]    pattern_sel_out;
  logic          busy;
  logic          done;
  logic [CW-1:0] sent_count;

  sequence_generator #(
    .IDLE_LEVEL (IDLE_LVL),
    .COUNT_W    (CW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_pattern     (cmd_pattern),
    .cmd_repeat      (cmd_repeat),
    .cmd_gap         (cmd_gap),
    .abort           (abort),
    .serial_out      (serial_out),
    .serial_valid    (serial_valid),
    .pattern_sel_out (pattern_sel_out),
    .busy            (busy),
    .done            (done),
    .sent_count      (sent_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: on accept, the whole expected cycle stream of the command
  // is laid out in a queue (one entry per post-edge cycle) and consumed one
  // entry per clock edge.
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic so;   // serial_out
    logic sv;   // serial_valid
    logic dn;   // done
    logic bz;   // busy
    logic inc;  // an instance completes on this edge
  } cyc_t;

  localparam cyc_t IDLE_C = '{so: IDLE_LVL, sv: 1'b0, dn: 1'b0, bz: 1'b0, inc: 1'b0};
  localparam cyc_t ARM_C  = '{so: IDLE_LVL, sv: 1'b0, dn: 1'b0, bz: 1'b1, inc: 1'b0};
  localparam cyc_t GAP_C  = '{so: IDLE_LVL, sv: 1'b0, dn: 1'b0, bz: 1'b1, inc: 1'b0};
  localparam cyc_t DONE_C = '{so: IDLE_LVL, sv: 1'b0, dn: 1'b1, bz: 1'b1, inc: 1'b0};

  cyc_t       q[$];
  cyc_t       cur = IDLE_C;
  logic [1:0] m_sel = 2'b00;
  int         m_count = 0;
  bit         m_rst = 1'b1;

  function automatic logic [4:0] ref_pat(input logic [1:0] s);
    case (s)
      2'b00:   return 5'b10111;
      2'b01:   return 5'b01010;
      2'b10:   return 5'b10101;
      default: return 5'b10100;
    endcase
  endfunction

  // Advances the model by one clock edge using the inputs the DUT just sampled.
  task automatic model_step();
    logic [4:0] p;
    if (reset) begin
      q.delete();
      cur     = IDLE_C;
      m_sel   = 2'b00;
      m_count = 0;
      m_rst   = 1'b1;
    end else begin
      if (!cur.bz && !m_rst && cmd_valid) begin
        p = ref_pat(cmd_pattern);
        q.delete();
        q.push_back(ARM_C);
        for (int i = 0; i < int'(cmd_repeat); i++) begin
          if (i > 0)
            for (int g = 0; g < int'(cmd_gap); g++) q.push_back(GAP_C);
          for (int b = 4; b >= 0; b--)
            q.push_back('{so: p[b], sv: 1'b1, dn: 1'b0, bz: 1'b1, inc: (b == 0)});
        end
        q.push_back(DONE_C);
        if (cmd_pattern != m_sel) m_count = 0;
        m_sel = cmd_pattern;
        cur   = q.pop_front();
      end else if (cur.bz && abort) begin
        q.delete();
        cur = IDLE_C;
      end else if (q.size() > 0) begin
        cur = q.pop_front();
      end else begin
        cur = IDLE_C;
      end
      m_rst = 1'b0;
      if (cur.inc && m_count < CMAX) m_count++;
    end
  endtask

  task automatic compare_all();
    check("serial_out",      32'(serial_out),      32'(cur.so));
    check("serial_valid",    32'(serial_valid),    32'(cur.sv));
    check("done",            32'(done),            32'(cur.dn));
    check("busy",            32'(busy),            32'(cur.bz));
    check("cmd_ready",       32'(cmd_ready),       32'(!cur.bz && !m_rst));
    check("pattern_sel_out", 32'(pattern_sel_out), 32'(m_sel));
    check("sent_count",      32'(sent_count),      32'(m_count));
  endtask

  // One clock: inputs set before the call are sampled on the rising edge;
  // the model follows that edge and outputs are compared on the falling edge.
  task automatic tick();
    @(negedge clk);
    model_step();
    compare_all();
  endtask

  // Issue one command and return the edge offset (after accept) of done.
  task automatic run_cmd(input logic [1:0] pat, input logic [7:0] rep,
                         input logic [3:0] gap, output int done_at);
    int k;
    k = 0;
    while (!cmd_ready && k < 100) begin
      tick();
      k++;
    end
    check("ready_before_cmd", 32'(cmd_ready), 32'd1);
    cmd_valid   = 1'b1;
    cmd_pattern = pat;
    cmd_repeat  = rep;
    cmd_gap     = gap;
    tick();
    done_at = -1;
    for (int i = 1; i <= 400; i++) begin
      // Junk on the command port while busy must be ignored.
      cmd_valid   = 1'($urandom);
      cmd_pattern = 2'($urandom);
      cmd_repeat  = 8'($urandom);
      cmd_gap     = 4'($urandom);
      tick();
      if (done) begin
        done_at = i;
        break;
      end
    end
    cmd_valid = 1'b0;
  endtask

  typedef struct {
    logic [1:0] pat;
    logic [7:0] rep;
    logic [3:0] gap;
    int         exp_done;  // edges from accept to the edge raising done
    int         exp_cnt;   // sent_count once done
  } vec_t;

  vec_t       vecs[7];
  int         got;
  logic [1:0] rp;

  initial begin
    // Directed commands, applied in order from reset (pattern 00, count 0).
    vecs[0] = '{2'b00, 8'd1, 4'd0,  6, 1};  // same pattern as reset: no clear
    vecs[1] = '{2'b10, 8'd3, 4'd2, 20, 3};  // new pattern clears, gaps of 2
    vecs[2] = '{2'b01, 8'd2, 4'd0, 11, 2};  // back-to-back instances
    vecs[3] = '{2'b11, 8'd1, 4'd0,  6, 1};  // pattern change clears
    vecs[4] = '{2'b11, 8'd2, 4'd0, 11, 3};  // same pattern continues count
    vecs[5] = '{2'b01, 8'd0, 4'd5,  1, 0};  // repeat 0: clear, no bits
    vecs[6] = '{2'b00, 8'd2, 4'd15, 26, 2}; // maximum gap

    // Reset state, with command and abort asserted to show reset dominates.
    reset = 1'b1; cmd_valid = 1'b1; abort = 1'b1;
    tick();
    tick();
    check("rst_cmd_ready",  32'(cmd_ready),  32'd0);
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_sent_count", 32'(sent_count), 32'd0);
    check("rst_serial_out", 32'(serial_out), 32'(IDLE_LVL));
    reset = 1'b0; cmd_valid = 1'b0; abort = 1'b0;
    tick();
    check("ready_after_rst", 32'(cmd_ready), 32'd1);

    for (int v = 0; v < 7; v++) begin
      run_cmd(vecs[v].pat, vecs[v].rep, vecs[v].gap, got);
      check($sformatf("vec%0d_done_edge", v), 32'(got), 32'(vecs[v].exp_done));
      check($sformatf("vec%0d_count", v), 32'(sent_count), 32'(vecs[v].exp_cnt));
      tick();
    end

    // Abort during the third bit of a 4-instance command.
    cmd_valid = 1'b1; cmd_pattern = 2'b01; cmd_repeat = 8'd4; cmd_gap = 4'd1;
    tick();
    cmd_valid = 1'b0;
    tick(); tick(); tick();
    check("abort_third_bit_valid", 32'(serial_valid), 32'd1);
    check("abort_third_bit_value", 32'(serial_out),   32'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy",    32'(busy),            32'd0);
    check("abort_done",    32'(done),            32'd0);
    check("abort_ready",   32'(cmd_ready),       32'd1);
    check("abort_count",   32'(sent_count),      32'd0);
    check("abort_sel",     32'(pattern_sel_out), 32'd1);
    tick();

    // Reset in the middle of a gap.
    cmd_valid = 1'b1; cmd_pattern = 2'b10; cmd_repeat = 8'd3; cmd_gap = 4'd2;
    tick();
    cmd_valid = 1'b0;
    repeat (6) tick();
    check("midgap_valid", 32'(serial_valid), 32'd0);
    check("midgap_busy",  32'(busy),         32'd1);
    check("midgap_count", 32'(sent_count),   32'd1);
    reset = 1'b1; cmd_valid = 1'b1; abort = 1'b1;
    tick();
    check("rst_gap_busy",  32'(busy),            32'd0);
    check("rst_gap_sel",   32'(pattern_sel_out), 32'd0);
    check("rst_gap_count", 32'(sent_count),      32'd0);
    check("rst_gap_ready", 32'(cmd_ready),       32'd0);
    reset = 1'b0; cmd_valid = 1'b0; abort = 1'b0;
    tick();
    check("rst_gap_ready_after", 32'(cmd_ready), 32'd1);

    // Abort together with accept in IDLE: the accept proceeds.
    cmd_valid = 1'b1; cmd_pattern = 2'b00; cmd_repeat = 8'd1; cmd_gap = 4'd0;
    abort = 1'b1;
    tick();
    cmd_valid = 1'b0; abort = 1'b0;
    check("accept_with_abort_busy", 32'(busy), 32'd1);
    got = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done) begin
        got = 1;
        break;
      end
    end
    check("accept_with_abort_done",  32'(got),        32'd1);
    check("accept_with_abort_count", 32'(sent_count), 32'd1);
    tick();

    // Randomized traffic; the pattern mostly repeats so the counter saturates.
    rp = 2'b00;
    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 3) == 0) rp = 2'($urandom);
      repeat ($urandom_range(0, 2)) begin
        abort = 1'($urandom);
        tick();
      end
      abort       = ($urandom_range(0, 3) == 0);
      cmd_valid   = 1'b1;
      cmd_pattern = rp;
      cmd_repeat  = 8'($urandom_range(0, 5));
      cmd_gap     = 4'($urandom_range(0, 4));
      tick();
      cmd_valid = 1'b0;
      abort     = 1'b0;
      for (int c = 0; c < 80 && busy; c++) begin
        abort       = ($urandom_range(0, 59) == 0);
        reset       = ($urandom_range(0, 149) == 0);
        cmd_valid   = 1'($urandom);
        cmd_pattern = 2'($urandom);
        cmd_repeat  = 8'($urandom);
        cmd_gap     = 4'($urandom);
        tick();
      end
      abort = 1'b0; reset = 1'b0; cmd_valid = 1'b0;
      check("rand_cmd_finished", 32'(busy), 32'd0);
    end
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sequence_generator.md
SEQUENCE_GENERATOR -- requirements
Module: sequence_generator

Interface
REQ-001 Parameter: IDLE_LEVEL, 1'b0, value driven on serial_out when no pattern bit is active.
REQ-002 Parameter: COUNT_W, 16, width of sent_count.
REQ-003 Port: clk  in  1  clock, all state updates on rising edge.
REQ-004 Port: reset  in  1  reset, synchronous, active-high.
REQ-005 Port: cmd_valid  in  1  command request.
REQ-006 Port: cmd_ready  out  1  block can accept a command.
REQ-007 Port: cmd_pattern  in  2  pattern select: 00=10111, 01=01010, 10=10101, 11=10100.
REQ-008 Port: cmd_repeat  in  8  number of pattern instances to send (0..255).
REQ-009 Port: cmd_gap  in  4  idle bits inserted between consecutive instances (0..15).
REQ-010 Port: abort  in  1  terminate current command.
REQ-011 Port: serial_out  out  1  serial pattern stream, feeds a detector's input_seq.
REQ-012 Port: serial_valid  out  1  serial_out carries a pattern bit.
REQ-013 Port: pattern_sel_out  out  2  currently selected pattern, feeds a detector's lookfor_seq.
REQ-014 Port: busy  out  1  high in every state except IDLE.
REQ-015 Port: done  out  1  one-cycle pulse on normal command completion.
REQ-016 Port: sent_count  out  COUNT_W  completed pattern instances since last clear.

Function
REQ-017 States SHALL be IDLE, ARM, SEND, GAP, DONE; cmd_ready = 1 only in IDLE and not in reset.
REQ-018 Accept SHALL occur on edge N when cmd_valid && cmd_ready: latch cmd_repeat and cmd_gap, set pattern_sel_out <= cmd_pattern, enter ARM.
REQ-019 If accepted cmd_pattern != previous pattern_sel_out, sent_count SHALL clear to 0 on edge N.
REQ-020 ARM SHALL last exactly one cycle; with repeat=0, ARM -> DONE and no bits are sent.
REQ-021 With repeat>0, ARM -> SEND; bits SHALL be driven MSB (bit 4) first on edges N+1..N+5, serial_valid = 1 for each.
REQ-022 On the edge driving bit 0, sent_count SHALL increment, saturating at all-ones.
REQ-023 After bit 0: remaining instances > 0 and gap > 0 -> GAP; remaining > 0 and gap = 0 -> next bit 4 on the following edge (back-to-back); remaining = 0 -> DONE.
REQ-024 GAP SHALL drive serial_out = IDLE_LEVEL, serial_valid = 0 for exactly cmd_gap cycles, then SEND.
REQ-025 DONE SHALL last one cycle with done = 1, serial_valid = 0, then IDLE.
REQ-026 Total cycles from accept edge to done pulse = 1 + 5*R + G*(R-1) + 1 for R>0; 2 for R=0.
REQ-027 cmd_* inputs SHALL be ignored outside IDLE.
REQ-028 abort in ARM/SEND/GAP/DONE SHALL force IDLE on next edge: serial_out = IDLE_LEVEL, serial_valid = 0, no done pulse, sent_count and pattern_sel_out held.
REQ-029 abort in IDLE SHALL be ignored; abort together with accept SHALL let the accept proceed.
REQ-030 Outside SEND, serial_out SHALL equal IDLE_LEVEL.

Reset
REQ-031 While reset is high, on every edge: state = IDLE, serial_out = IDLE_LEVEL, serial_valid = 0, pattern_sel_out = 00, busy = 0, done = 0, sent_count = 0, cmd_ready = 0.
REQ-032 Reset SHALL dominate abort and cmd_valid, including mid-pattern; cmd_ready = 1 from the first edge after reset deasserts.

Structure
REQ-033 Shared package seqgen_pkg SHALL hold the state enum, the four 5-bit pattern constants, and the pattern-select encoding, shared with detector benches.
REQ-034 Sub-module seq_pattern_lut SHALL map 2-bit select to 5-bit pattern; all other logic in sequence_generator.

Verification
REQ-035 Pattern 00, repeat 1, gap 0 -> serial_out 1,0,1,1,1 on edges N+1..N+5, done at N+6, sent_count = 1.
REQ-036 Pattern 10, repeat 3, gap 2 -> 10101,00,10101,00,10101; serial_valid low during gaps; done at N+20; sent_count = 3.
REQ-037 Pattern 01, repeat 2, then pattern 11, repeat 1 -> sent_count 2, clears at second accept, ends at 1; same pattern resent -> count continues to 3.
REQ-038 Abort asserted during third bit of repeat 4 -> IDLE next edge, no done, sent_count unchanged, cmd_ready = 1.
REQ-039 Reset asserted mid-GAP -> all outputs at reset values on next edge; repeat=0 command -> done 2 cycles after accept, no serial_valid.
REQ-040 Loop-back into the existing detector, all four patterns, gap 3 -> detector seq_count equals sent_count.
